// File: rtl/round_pack_f64_arbiter_if.sv
// round_pack_f64_arbiter_if
//   Requester-side bus of the shared roundAndPackFloat64 arbiter.
//   Carries the per-requester request lanes (packed, lane i at bits
//   [W*i +: W]), the per-requester sticky flag view and clear strobes,
//   and the single shared response channel.
//   master : the requesters / response consumer (drives req_*, flag_clr, resp_ready)
//   slave  : the arbiter (drives req_ready, flags, resp_*)
interface round_pack_f64_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_sign;
  logic [12*NUM_REQ-1:0] req_exp;
  logic [64*NUM_REQ-1:0] req_sig;
  logic [NUM_REQ-1:0]    flag_clr;
  logic [32*NUM_REQ-1:0] flags;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [63:0]           resp_data;
  logic [31:0]           resp_flags;

  modport master (
    output req_valid, req_sign, req_exp, req_sig, flag_clr, resp_ready,
    input  req_ready, flags, resp_valid, resp_id, resp_data, resp_flags
  );

  modport slave (
    input  req_valid, req_sign, req_exp, req_sig, flag_clr, resp_ready,
    output req_ready, flags, resp_valid, resp_id, resp_data, resp_flags
  );
endinterface

// File: rtl/round_pack_f64_arbiter.sv
// round_pack_f64_arbiter
//   Shares one roundAndPackFloat64 core among NUM_REQ requesters. Grants
//   round-robin, runs the core's ap_start/ap_ready handshake, threads a
//   sticky 32-bit exception-flag register per requester through the core,
//   and returns each result tagged with its requester id.
// Ports
//   ap_clk, ap_rst    : clock, asynchronous active-high reset (shared with core)
//   bus (slave)       : requester lanes, flag view/clear, response channel
//   key_in            : working key, forwarded to core_working_key
//   core_*            : control, operands and flag threading of the core
module round_pack_f64_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  round_pack_f64_arbiter_if.slave     bus,
  input  logic [6:0]                  key_in,
  output logic [6:0]                  core_working_key,
  output logic                        core_start,
  input  logic                        core_ready,
  input  logic                        core_done,
  input  logic                        core_idle,
  output logic                        core_zSign,
  output logic [11:0]                 core_zExp,
  output logic [63:0]                 core_zSig,
  output logic [31:0]                 core_flag_i,
  input  logic [31:0]                 core_flag_o,
  input  logic                        core_flag_o_vld,
  input  logic [63:0]                 core_return
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic                core_start_q, core_start_d;
  logic                op_sign_q, op_sign_d;
  logic [11:0]         op_exp_q, op_exp_d;
  logic [63:0]         op_sig_q, op_sig_d;
  logic [31:0]         core_flag_i_q, core_flag_i_d;
  logic [31:0]         tmp_flags_q, tmp_flags_d;
  logic                resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic [63:0]         resp_data_q, resp_data_d;
  logic [31:0]         resp_flags_q, resp_flags_d;

  logic [NUM_REQ-1:0][31:0] flags_vec;
  logic                     grant_found;
  logic [ID_W-1:0]          grant_idx;
  logic                     wb_en;
  logic [31:0]              final_flags;

  // ap_done/ap_idle are deliberately ignored: the core holds ap_done high
  // while idle, so completion is taken from ap_ready only.
  logic unused_core_status;
  assign unused_core_status = &{1'b0, core_done, core_idle};

  // Write-back happens on the ap_ready cycle; a flag update arriving on that
  // same cycle has not reached tmp_flags yet, so take it directly.
  assign wb_en       = (state_q == WAIT) && core_ready;
  assign final_flags = core_flag_o_vld ? core_flag_o : tmp_flags_q;

  // First valid requester at or after the round-robin pointer, cyclically.
  always_comb begin
    logic [ID_W:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (ID_W+1)'(rr_q) + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!grant_found && bus.req_valid[idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[ID_W-1:0];
      end
    end
  end

  // Sticky flag registers: clear beats a coinciding write-back.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_flag
    logic [31:0] flag_q, flag_d;
    always_comb begin
      flag_d = flag_q;
      if (wb_en && (owner_q == ID_W'(gi))) flag_d = final_flags;
      if (bus.flag_clr[gi]) flag_d = 32'd0;
    end
    always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) flag_q <= 32'd0;
      else        flag_q <= flag_d;
    end
    assign flags_vec[gi]          = flag_q;
    assign bus.flags[32*gi +: 32] = flag_q;
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    owner_d       = owner_q;
    req_ready_d   = '0;
    core_start_d  = core_start_q;
    op_sign_d     = op_sign_q;
    op_exp_d      = op_exp_q;
    op_sig_d      = op_sig_q;
    core_flag_i_d = core_flag_i_q;
    tmp_flags_d   = tmp_flags_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_data_d   = resp_data_q;
    resp_flags_d  = resp_flags_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready_d[grant_idx] = 1'b1;
          op_sign_d    = bus.req_sign[grant_idx];
          op_exp_d     = bus.req_exp[12*grant_idx +: 12];
          op_sig_d     = bus.req_sig[64*grant_idx +: 64];
          owner_d      = grant_idx;
          // Snapshot of the owner's flags seen by the core for the whole
          // operation; a later clear does not disturb the in-flight op.
          core_flag_i_d = bus.flag_clr[grant_idx] ? 32'd0 : flags_vec[grant_idx];
          tmp_flags_d   = core_flag_i_d;
          core_start_d  = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (core_flag_o_vld) tmp_flags_d = core_flag_o;
        if (core_ready) begin
          resp_data_d  = core_return;
          resp_id_d    = owner_q;
          resp_flags_d = final_flags;
          resp_valid_d = 1'b1;
          core_start_d = 1'b0;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          rr_d    = (owner_q == ID_W'(NUM_REQ-1)) ? '0 : owner_q + ID_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q       <= IDLE;
      rr_q          <= '0;
      owner_q       <= '0;
      req_ready_q   <= '0;
      core_start_q  <= 1'b0;
      op_sign_q     <= 1'b0;
      op_exp_q      <= 12'd0;
      op_sig_q      <= 64'd0;
      core_flag_i_q <= 32'd0;
      tmp_flags_q   <= 32'd0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_data_q   <= 64'd0;
      resp_flags_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      owner_q       <= owner_d;
      req_ready_q   <= req_ready_d;
      core_start_q  <= core_start_d;
      op_sign_q     <= op_sign_d;
      op_exp_q      <= op_exp_d;
      op_sig_q      <= op_sig_d;
      core_flag_i_q <= core_flag_i_d;
      tmp_flags_q   <= tmp_flags_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_data_q   <= resp_data_d;
      resp_flags_q  <= resp_flags_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_id        = resp_id_q;
  assign bus.resp_data      = resp_data_q;
  assign bus.resp_flags     = resp_flags_q;
  assign core_working_key   = key_in;
  assign core_start         = core_start_q;
  assign core_zSign         = op_sign_q;
  assign core_zExp          = op_exp_q;
  assign core_zSig          = op_sig_q;
  assign core_flag_i        = core_flag_i_q;

endmodule

// File: tb/tb_round_pack_f64_arbiter.sv
// Testbench for round_pack_f64_arbiter: behavioural roundAndPackFloat64
// core model (latency from the working key, overflow takes the short path)
// plus a linear directed sequence with hand-computed expected values.
module tb_round_pack_f64_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b0;
  always #5 ap_clk = ~ap_clk;

  round_pack_f64_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  logic [6:0]  key_in, core_working_key;
  logic        core_start, core_ready, core_done, core_idle, core_zSign, core_flag_o_vld;
  logic [11:0] core_zExp;
  logic [63:0] core_zSig, core_return;
  logic [31:0] core_flag_i, core_flag_o;

  round_pack_f64_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus),
    .key_in(key_in), .core_working_key(core_working_key),
    .core_start(core_start), .core_ready(core_ready), .core_done(core_done),
    .core_idle(core_idle), .core_zSign(core_zSign), .core_zExp(core_zExp),
    .core_zSig(core_zSig), .core_flag_i(core_flag_i), .core_flag_o(core_flag_o),
    .core_flag_o_vld(core_flag_o_vld), .core_return(core_return)
  );

  // ---------------- core model ----------------
  // Returns {overflow, new_flags, result}; round-to-nearest-even, normal range.
  function automatic logic [96:0] rp(input logic s, input logic [11:0] e, input logic [63:0] z);
    logic [9:0]  rb;
    logic [63:0] sum, m;
    logic [11:0] ee;
    rb  = z[9:0];
    sum = z + 64'h200;
    if (e > 12'h7FD || (e == 12'h7FD && sum[63]))
      return {1'b1, 32'h9, s, 11'h7FF, 52'd0};
    m = sum >> 10;
    if (rb == 10'h200) m[0] = 1'b0;
    ee = (m == 64'd0) ? 12'd0 : e;
    return {1'b0, (rb != 10'd0) ? 32'h1 : 32'h0, {s, 63'd0} + {ee, 52'd0} + m};
  endfunction

  logic [96:0] m_calc;
  int          m_lat;
  logic        m_busy, m_early;
  int          m_cnt;
  logic [63:0] m_res;
  logic [31:0] m_flo;

  always_comb begin
    m_calc = rp(core_zSign, core_zExp, core_zSig);
    m_lat  = 2 + int'(core_working_key[1:0]);
    if (m_lat > 4) m_lat = 4;
    if (m_calc[96]) m_lat = 2;
  end

  always @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      m_busy <= 1'b0; m_early <= 1'b0; m_cnt <= 0; m_res <= 64'd0; m_flo <= 32'd0;
    end else if (!m_busy && core_start) begin
      m_busy  <= 1'b1;
      m_cnt   <= m_lat - 1;
      m_early <= core_working_key[2] && (m_lat >= 3);
      m_res   <= m_calc[63:0];
      m_flo   <= core_flag_i | m_calc[95:64];
    end else if (m_busy) begin
      if (m_cnt == 0) m_busy <= 1'b0;
      else            m_cnt  <= m_cnt - 1;
    end
  end

  assign core_ready      = m_busy && (m_cnt == 0);
  assign core_flag_o_vld = m_busy && (m_early ? (m_cnt == 1) : (m_cnt == 0));
  assign core_flag_o     = m_flo;
  assign core_return     = m_res;
  assign core_done       = !m_busy;
  assign core_idle       = !m_busy;

  // ---------------- checking helpers ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    $display("vector %0d %s: observed %h expected %h", vectors, tag, obs, exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int id, input logic s, input logic [11:0] e, input logic [63:0] z);
    logic [3:0] oh;
    int n;
    oh = 4'b0001 << id;
    bus.req_sign[id]            = s;
    bus.req_exp[12*id +: 12]    = e;
    bus.req_sig[64*id +: 64]    = z;
    bus.req_valid[id]           = 1'b1;
    n = 0;
    while (!bus.req_ready[id] && n < 20) begin tick(); n++; end
    check("req_ready_onehot", 64'(bus.req_ready), 64'(oh));
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_resp(output int cycles);
    cycles = 0;
    while (!bus.resp_valid && cycles < 30) begin tick(); cycles++; end
    check("resp_valid_seen", 64'(bus.resp_valid), 64'd1);
  endtask

  task automatic accept();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  int cyc;
  int n;
  logic saw;
  logic [2:0] rr_exp [5];

  initial begin
    bus.req_valid = '0; bus.req_sign = '0; bus.req_exp = '0; bus.req_sig = '0;
    bus.flag_clr = '0; bus.resp_ready = 1'b0; key_in = 7'h00;
    rr_exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};

    // Reset state
    #2 ap_rst = 1'b1;
    #1;
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_req_ready",  64'(bus.req_ready), 64'd0);
    check("rst_flags",      64'(bus.flags[63:0]), 64'd0);
    check("rst_resp_data",  bus.resp_data, 64'd0);
    @(posedge ap_clk); #3 ap_rst = 1'b0;
    tick();

    // Exact result
    key_in = 7'h05;
    check("key_passthrough", 64'(core_working_key), 64'h05);
    issue(0, 1'b0, 12'h3FF, 64'h4000000000000000);
    wait_resp(cyc);
    check("exact_id",    64'(bus.resp_id), 64'd0);
    check("exact_data",  bus.resp_data, 64'h4000000000000000);
    check("exact_rflag", 64'(bus.resp_flags), 64'h0);
    check("exact_flags0", 64'(bus.flags[31:0]), 64'h0);
    accept();

    // Inexact result, then again with the early flag pulse (sticky)
    key_in = 7'h01;
    issue(1, 1'b0, 12'h3FF, 64'h4000000000000001);
    wait_resp(cyc);
    check("inexact_id",    64'(bus.resp_id), 64'd1);
    check("inexact_data",  bus.resp_data, 64'h4000000000000000);
    check("inexact_rflag", 64'(bus.resp_flags), 64'h1);
    check("inexact_flags1", 64'(bus.flags[63:32]), 64'h1);
    accept();
    key_in = 7'h06;
    issue(1, 1'b0, 12'h3FF, 64'h4000000000000001);
    wait_resp(cyc);
    check("inexact2_data",  bus.resp_data, 64'h4000000000000000);
    check("inexact2_rflag", 64'(bus.resp_flags), 64'h1);
    check("inexact2_flags1", 64'(bus.flags[63:32]), 64'h1);
    accept();

    // Overflow, short core path
    key_in = 7'h03;
    issue(2, 1'b1, 12'h7FE, 64'h4000000000000000);
    wait_resp(cyc);
    check("ovf_latency_le3", 64'(cyc <= 3), 64'd1);
    check("ovf_id",    64'(bus.resp_id), 64'd2);
    check("ovf_data",  bus.resp_data, 64'hFFF0000000000000);
    check("ovf_rflag", 64'(bus.resp_flags), 64'h9);
    check("ovf_flags2", 64'(bus.flags[95:64]), 64'h9);
    accept();

    // Clear colliding with write-back
    key_in = 7'h00;
    issue(1, 1'b0, 12'h3FF, 64'h4000000000000001);
    n = 0;
    while (!core_ready && n < 20) begin tick(); n++; end
    check("clr_core_ready_seen", 64'(core_ready), 64'd1);
    bus.flag_clr[1] = 1'b1;
    tick();
    bus.flag_clr = '0;
    check("clr_resp_valid", 64'(bus.resp_valid), 64'd1);
    check("clr_rflag",  64'(bus.resp_flags), 64'h1);
    check("clr_flags1", 64'(bus.flags[63:32]), 64'h0);
    accept();

    // Asynchronous reset during WAIT
    key_in = 7'h03;
    issue(0, 1'b0, 12'h3FF, 64'h4000000000000000);
    tick();
    #3 ap_rst = 1'b1;
    #1;
    check("arst_core_start", 64'(core_start), 64'd0);
    check("arst_resp_data",  bus.resp_data, 64'd0);
    check("arst_resp_flags", 64'(bus.resp_flags), 64'd0);
    check("arst_flags",      64'(bus.flags[95:64]), 64'd0);
    @(posedge ap_clk); #3 ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.resp_valid) saw = 1'b1;
      tick();
    end
    check("arst_no_resp", 64'(saw), 64'd0);

    // Round-robin with all four requesting
    key_in = 7'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_exp[12*i +: 12] = 12'h3FF;
      bus.req_sig[64*i +: 64] = 64'h4000000000000000;
    end
    bus.req_sign   = '0;
    bus.req_valid  = 4'hF;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_resp(cyc);
      check($sformatf("rr_id_%0d", i), 64'(bus.resp_id), 64'(rr_exp[i]));
      tick();
    end
    bus.resp_ready = 1'b0;
    wait_resp(cyc);
    check("stall_id", 64'(bus.resp_id), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 64'(bus.resp_valid), 64'd1);
      check("stall_data",  bus.resp_data, 64'h4000000000000000);
      check("stall_id_hold", 64'(bus.resp_id), 64'd1);
      check("stall_no_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
